// File: rtl/mine_placer.sv
// mine_placer: builds the mine map for a new game. A free-running 8-bit LFSR
// proposes one cell index per cycle. The FSM keeps a proposal only if it is on
// the board, not already a mine, and not the excluded cell. It stops once
// NUM_MINES mines are placed, then pulses place_done for one cycle. The map
// holds until the next start or reset.
//
// Handshake: start is a level that is sampled only while the FSM is in IDLE.
// There is no ready/acknowledge, and a start seen in any other state is
// dropped, not queued. place_done is a single-cycle valid strobe. mines and
// mine_count are valid from that cycle and stay stable until the next accepted
// start or reset.
module mine_placer #(
  parameter int          CELLS     = 25,
  parameter int          NUM_MINES = 4,
  parameter logic [7:0]  SEED      = 8'hA5
) (
  input  logic             clka,
  input  logic             restart_n,
  input  logic             start,
  input  logic             seed_load,
  input  logic [7:0]       seed,
  input  logic             avoid_en,
  input  logic [4:0]       avoid,
  output logic             busy,
  output logic             place_done,
  output logic [CELLS-1:0] mines,
  output logic [4:0]       mine_count,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    PLACE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [4:0] TARGET    = 5'(NUM_MINES);
  localparam logic [5:0] CELLS_LIM = 6'(CELLS);

  state_t           state, state_next;
  logic [7:0]       lfsr;
  logic             lfsr_fb;
  logic [4:0]       cand;
  logic [31:0]      cand_onehot;
  logic [31:0]      mines_ext;
  logic             cand_on_board;
  logic             cand_taken;
  logic             cand_excluded;
  logic             accept;
  logic [4:0]       count_inc;
  logic [CELLS-1:0] mines_next;
  logic [4:0]       count_next;

  // Candidate decode: the index comes from the current LFSR value, not the next one
  assign lfsr_fb       = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign cand          = lfsr[4:0];
  assign cand_onehot   = 32'd1 << cand;
  assign mines_ext     = 32'(mines);
  assign cand_on_board = ({1'b0, cand} < CELLS_LIM);
  assign cand_taken    = mines_ext[cand];
  assign cand_excluded = avoid_en && ({1'b0, avoid} < CELLS_LIM) && (cand == avoid);
  assign accept        = cand_on_board && !cand_taken && !cand_excluded;
  assign count_inc     = 5'(mine_count + 5'd1);

  // LFSR steps every cycle in every state; a loaded seed of zero would lock up, so SEED replaces it
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      lfsr <= SEED;
    end else if (seed_load) begin
      lfsr <= (seed == 8'h00) ? SEED : seed;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
    end
  end

  // State and map registers; reset drops any partially built map at once
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state      <= IDLE;
      mines      <= '0;
      mine_count <= '0;
    end else begin
      state      <= state_next;
      mines      <= mines_next;
      mine_count <= count_next;
    end
  end

  // Next-state and map update: one candidate is judged in each PLACE cycle
  always_comb begin
    state_next = state;
    mines_next = mines;
    count_next = mine_count;
    case (state)
      IDLE: begin
        if (start) state_next = CLEAR;
      end
      CLEAR: begin
        mines_next = '0;
        count_next = '0;
        state_next = PLACE;
      end
      PLACE: begin
        if (accept) begin
          mines_next = mines | cand_onehot[CELLS-1:0];
          count_next = count_inc;
          if (count_inc == TARGET) state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    busy       = (state == CLEAR) || (state == PLACE);
    place_done = (state == DONE);
    fsm_state  = state;
  end

endmodule

// File: tb/tb_mine_placer.sv
// Directed bench for mine_placer. Three instances share the seed and avoid
// inputs and differ in NUM_MINES (1, 4 and 24). Each instance has its own start.
module tb_mine_placer;

  logic        clka;
  logic        restart_n;
  logic        seed_load;
  logic [7:0]  seed;
  logic        avoid_en;
  logic [4:0]  avoid;
  logic        start1, start4, start24;

  logic        busy1, busy4, busy24;
  logic        done1, done4, done24;
  logic [24:0] mines1, mines4, mines24;
  logic [4:0]  cnt1, cnt4, cnt24;
  logic [1:0]  st1, st4, st24;

  int n_vec = 0;
  int n_err = 0;

  // Clock and reset
  initial clka = 1'b0;
  always #5 clka = ~clka;

  mine_placer #(.CELLS(25), .NUM_MINES(1), .SEED(8'hA5)) dut1 (
    .clka(clka), .restart_n(restart_n), .start(start1), .seed_load(seed_load),
    .seed(seed), .avoid_en(avoid_en), .avoid(avoid), .busy(busy1),
    .place_done(done1), .mines(mines1), .mine_count(cnt1), .fsm_state(st1)
  );

  mine_placer #(.CELLS(25), .NUM_MINES(4), .SEED(8'hA5)) dut4 (
    .clka(clka), .restart_n(restart_n), .start(start4), .seed_load(seed_load),
    .seed(seed), .avoid_en(avoid_en), .avoid(avoid), .busy(busy4),
    .place_done(done4), .mines(mines4), .mine_count(cnt4), .fsm_state(st4)
  );

  mine_placer #(.CELLS(25), .NUM_MINES(24), .SEED(8'hA5)) dut24 (
    .clka(clka), .restart_n(restart_n), .start(start24), .seed_load(seed_load),
    .seed(seed), .avoid_en(avoid_en), .avoid(avoid), .busy(busy24),
    .place_done(done24), .mines(mines24), .mine_count(cnt24), .fsm_state(st24)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic done_of(input int which);
    case (which)
      1:       return done1;
      4:       return done4;
      default: return done24;
    endcase
  endfunction

  // Waits on negedges until place_done of the chosen instance, bounded by max_cyc
  task automatic wait_done(input int which, input int max_cyc, output int cyc);
    cyc = 0;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clka);
      if (done_of(which)) begin
        cyc = k;
        break;
      end
    end
    if (cyc == 0) chk("timeout_place_done", 32'd0, 32'd1);
  endtask

  int cyc;
  int extra_done;

  initial begin
    restart_n = 1'b0;
    seed_load = 1'b0;
    seed      = 8'h00;
    avoid_en  = 1'b0;
    avoid     = 5'd0;
    start1    = 1'b0;
    start4    = 1'b0;
    start24   = 1'b0;

    // Reset state
    repeat (2) @(negedge clka);
    chk("rst_mines",  32'(mines4), 32'd0);
    chk("rst_count",  32'(cnt4),   32'd0);
    chk("rst_busy",   32'(busy4),  32'd0);
    chk("rst_done",   32'(done4),  32'd0);
    chk("rst_state",  32'(st4),    32'd0);
    restart_n = 1'b1;

    // NUM_MINES=1, seed 01 loaded together with start: CLEAR sees 01, PLACE proposes cell 2
    @(negedge clka);
    seed_load = 1'b1; seed = 8'h01; start1 = 1'b1;
    @(negedge clka);
    seed_load = 1'b0; start1 = 1'b0;
    chk("t2_busy_clear", 32'(busy1), 32'd1);
    @(negedge clka);
    chk("t2_place_mines", 32'(mines1), 32'd0);
    @(negedge clka);
    chk("t2_mines", 32'(mines1), 32'h0000004);
    chk("t2_done",  32'(done1),  32'd1);
    chk("t2_count", 32'(cnt1),   32'd1);
    @(negedge clka);
    chk("t2_done_low",  32'(done1),  32'd0);
    chk("t2_busy_low",  32'(busy1),  32'd0);
    chk("t2_mines_hold", 32'(mines1), 32'h0000004);

    // Same with cell 2 excluded: 2 rejected, next proposal 4 accepted one cycle later
    seed_load = 1'b1; seed = 8'h01; start1 = 1'b1; avoid_en = 1'b1; avoid = 5'd2;
    @(negedge clka);
    seed_load = 1'b0; start1 = 1'b0;
    @(negedge clka);
    @(negedge clka);
    chk("t3_reject_done", 32'(done1),  32'd0);
    chk("t3_reject_busy", 32'(busy1),  32'd1);
    chk("t3_reject_map",  32'(mines1), 32'd0);
    @(negedge clka);
    chk("t3_mines", 32'(mines1), 32'h0000010);
    chk("t3_done",  32'(done1),  32'd1);
    avoid_en = 1'b0; avoid = 5'd0;

    // Reset during PLACE of the 24-mine instance takes effect without a clock edge
    @(negedge clka);
    start24 = 1'b1;
    @(negedge clka);
    start24 = 1'b0;
    repeat (10) @(negedge clka);
    chk("t1_busy_before", 32'(busy24), 32'd1);
    restart_n = 1'b0;
    #1;
    chk("t1_mines", 32'(mines24), 32'd0);
    chk("t1_busy",  32'(busy24),  32'd0);
    chk("t1_done",  32'(done24),  32'd0);
    chk("t1_count", 32'(cnt24),   32'd0);
    chk("t1_state", 32'(st24),    32'd0);
    // Release and start on the first edge: lfsr=A5 there, CLEAR sees 4A,
    // proposals 21,10,20,9 all accepted -> done 6 cycles after start
    @(negedge clka);
    restart_n = 1'b1; start4 = 1'b1;
    @(negedge clka);
    start4 = 1'b0;
    wait_done(4, 300, cyc);
    chk("t1_latency", 32'(cyc + 1), 32'd6);
    chk("t1_mines_restart", 32'(mines4), 32'h0300600);
    chk("t1_count_restart", 32'(cnt4),   32'd4);

    // Seed 00 must behave as SEED: CLEAR sees A5, proposals 10,21,10(dup),20,9
    @(negedge clka);
    seed_load = 1'b1; seed = 8'h00; start4 = 1'b1;
    @(negedge clka);
    seed_load = 1'b0; start4 = 1'b0;
    wait_done(4, 300, cyc);
    chk("t5_seed0_latency", 32'(cyc + 1), 32'd7);
    chk("t5_seed0_mines",   32'(mines4), 32'h0300600);
    @(negedge clka);
    seed_load = 1'b1; seed = 8'hA5; start4 = 1'b1;
    @(negedge clka);
    seed_load = 1'b0; start4 = 1'b0;
    wait_done(4, 300, cyc);
    chk("t5_seedA5_latency", 32'(cyc + 1), 32'd7);
    chk("t5_seedA5_mines",   32'(mines4), 32'h0300600);

    // start pulsed while busy and again on place_done: both dropped
    @(negedge clka);
    seed_load = 1'b1; seed = 8'hA5; start4 = 1'b1;
    @(negedge clka);
    seed_load = 1'b0; start4 = 1'b0;
    @(negedge clka);
    start4 = 1'b1;
    @(negedge clka);
    start4 = 1'b0;
    wait_done(4, 300, cyc);
    chk("t6_latency", 32'(cyc + 3), 32'd7);
    start4 = 1'b1;
    @(negedge clka);
    start4 = 1'b0;
    extra_done = 0;
    for (int k = 0; k < 10; k++) begin
      if (done4 || busy4) extra_done++;
      @(negedge clka);
    end
    chk("t6_no_restart", 32'(extra_done), 32'd0);
    chk("t6_mines_kept", 32'(mines4), 32'h0300600);
    chk("t6_state_idle", 32'(st4), 32'd0);

    // 24 mines with cell 0 excluded across random seeds
    avoid_en = 1'b1; avoid = 5'd0;
    for (int r = 0; r < 20; r++) begin
      seed_load = 1'b1; seed = 8'($urandom_range(0, 255)); start24 = 1'b1;
      @(negedge clka);
      seed_load = 1'b0; start24 = 1'b0;
      wait_done(24, 24 * 255 + 4, cyc);
      chk("t4_popcount", 32'($countones(mines24)), 32'd24);
      chk("t4_cell0",    32'(mines24[0]),          32'd0);
      chk("t4_count",    32'(cnt24),               32'd24);
      @(negedge clka);
    end
    avoid_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
